// File: rtl/demoman_pkg.sv
// Shared definitions for the second-generation fighter controller.
// - pstate_e : player state codes as seen on the state output
// - geometry : sprite width and hitbox/hurtbox offsets, written for a
//              right-facing sprite (the box mirror flips them for SIDE 1)
package demoman_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_MOVE_FWD     = 4'd1,
    ST_MOVE_BACK    = 4'd2,
    ST_ATK_STARTUP  = 4'd3,
    ST_ATK_ACTIVE   = 4'd4,
    ST_ATK_RECOVERY = 4'd5,
    ST_HITSTUN      = 4'd6,
    ST_BLOCKSTUN    = 4'd7,
    ST_KO           = 4'd8
  } pstate_e;

  localparam int SW      = 150;
  localparam int HB_X_LO = 37;
  localparam int HB_X_HI = 113;
  localparam int HB_Y_LO = 24;
  localparam int HB_Y_HI = 57;
  localparam int HU_X_LO = 37;
  localparam int HU_X_HI = 86;
  localparam int HU_Y_LO = 0;
  localparam int HU_Y_HI = 150;

endpackage

// File: rtl/player_box_mirror.sv
// Box corner generator for one collision box.
// Ports:
//   posx_i, posy_i : sprite origin (left edge, top)
//   x1_o..y2_o     : box corners, x1_o <= x2_o for either facing
// SIDE 1 sprites face left, so the x offsets are reflected about the sprite
// width; the reflection is folded into constants, leaving two adders per axis.
module player_box_mirror
  import demoman_pkg::*;
#(
  parameter int W    = 10,
  parameter int SIDE = 0,
  parameter int X_LO = 0,
  parameter int X_HI = 0,
  parameter int Y_LO = 0,
  parameter int Y_HI = 0
) (
  input  logic [W-1:0] posx_i,
  input  logic [W-1:0] posy_i,
  output logic [W-1:0] x1_o,
  output logic [W-1:0] x2_o,
  output logic [W-1:0] y1_o,
  output logic [W-1:0] y2_o
);

  localparam logic [W-1:0] XA = (SIDE == 0) ? W'(X_LO) : W'(SW - X_HI);
  localparam logic [W-1:0] XB = (SIDE == 0) ? W'(X_HI) : W'(SW - X_LO);
  localparam logic [W-1:0] YA = W'(Y_LO);
  localparam logic [W-1:0] YB = W'(Y_HI);

  assign x1_o = posx_i + XA;
  assign x2_o = posx_i + XB;
  assign y1_o = posy_i + YA;
  assign y2_o = posy_i + YB;

endmodule

// File: rtl/player_fsm_v2.sv
// Per-player fighter controller, advancing once per frame_tick.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   frame_tick                 : one-clk pulse per frame, gates all updates
//   left, right, attack        : debounced player controls (level)
//   hit_in                     : opponent hitbox overlaps our hurtbox
//   posx, posy, state          : sprite position and state code
//   hitbox_active, hitbox_*    : attack box (live only in ATK_ACTIVE)
//   hurtbox_*                  : body box
//   health, ko                 : remaining health, knocked-out flag
module player_fsm_v2
  import demoman_pkg::*;
#(
  parameter int SIDE        = 0,
  parameter int W           = 10,
  parameter int X_INIT_L    = 210,
  parameter int X_INIT_R    = 420,
  parameter int X_MIN       = 50,
  parameter int X_MAX       = 490,
  parameter int POS_Y       = 170,
  parameter int SPEED       = 5,
  parameter int STARTUP_F   = 5,
  parameter int ACTIVE_F    = 2,
  parameter int RECOVERY_F  = 16,
  parameter int HITSTUN_F   = 12,
  parameter int BLOCKSTUN_F = 6,
  parameter int KNOCKBACK   = 8,
  parameter int HEALTH_MAX  = 100,
  parameter int DAMAGE      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_tick,
  input  logic         left,
  input  logic         right,
  input  logic         attack,
  input  logic         hit_in,
  output logic [W-1:0] posx,
  output logic [W-1:0] posy,
  output logic [3:0]   state,
  output logic         hitbox_active,
  output logic [W-1:0] hitbox_x1,
  output logic [W-1:0] hitbox_x2,
  output logic [W-1:0] hitbox_y1,
  output logic [W-1:0] hitbox_y2,
  output logic [W-1:0] hurtbox_x1,
  output logic [W-1:0] hurtbox_x2,
  output logic [W-1:0] hurtbox_y1,
  output logic [W-1:0] hurtbox_y2,
  output logic [7:0]   health,
  output logic         ko
);

  typedef logic signed [W+1:0] sx_t;

  localparam logic [W-1:0] X_INIT = (SIDE == 0) ? W'(X_INIT_L) : W'(X_INIT_R);
  localparam logic [7:0]   DMG    = 8'(DAMAGE);
  // Signed step toward the opponent; "backward" is its negation.
  localparam sx_t FWD_STEP = (SIDE == 0) ? sx_t'(SPEED) : -sx_t'(SPEED);
  localparam sx_t FWD_KB   = (SIDE == 0) ? sx_t'(KNOCKBACK) : -sx_t'(KNOCKBACK);
  localparam sx_t XLO      = sx_t'(X_MIN);
  localparam sx_t XHI      = sx_t'(X_MAX);

  pstate_e        state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [W-1:0]   posx_q, posx_d;
  logic [7:0]     health_q, health_d;
  logic           atk_q;

  logic           atk_edge, mv_fwd, mv_back, expire, kb, timed;
  logic [7:0]     len;
  sx_t            step, nx;

  always_comb begin
    len   = 8'd1;
    timed = 1'b1;
    case (state_q)
      ST_ATK_STARTUP:  len = 8'(STARTUP_F);
      ST_ATK_ACTIVE:   len = 8'(ACTIVE_F);
      ST_ATK_RECOVERY: len = 8'(RECOVERY_F);
      ST_HITSTUN:      len = 8'(HITSTUN_F);
      ST_BLOCKSTUN:    len = 8'(BLOCKSTUN_F);
      default:         timed = 1'b0;
    endcase
  end

  assign expire   = (cnt_q == len - 8'd1);
  assign atk_edge = attack & ~atk_q;
  // Both directions held counts as retreat (guard), so forward needs exactly one.
  assign mv_fwd   = (SIDE == 0) ? (right & ~left) : (left & ~right);
  assign mv_back  = (left | right) & ~mv_fwd;

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    kb       = 1'b0;
    if (state_q > ST_KO) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_KO) begin
      state_d = ST_KO;
    end else if (hit_in && state_q != ST_HITSTUN) begin
      if (state_q == ST_MOVE_BACK || state_q == ST_BLOCKSTUN) begin
        state_d = ST_BLOCKSTUN;
        kb      = 1'b1;
      end else if (health_q <= DMG) begin
        health_d = '0;
        state_d  = ST_KO;
      end else begin
        health_d = health_q - DMG;
        state_d  = ST_HITSTUN;
        kb       = 1'b1;
      end
    end else begin
      case (state_q)
        ST_ATK_STARTUP:  if (expire) state_d = ST_ATK_ACTIVE;
        ST_ATK_ACTIVE:   if (expire) state_d = ST_ATK_RECOVERY;
        ST_ATK_RECOVERY,
        ST_HITSTUN,
        ST_BLOCKSTUN:    if (expire) state_d = ST_IDLE;
        default: begin
          if (atk_edge)     state_d = ST_ATK_STARTUP;
          else if (mv_fwd)  state_d = ST_MOVE_FWD;
          else if (mv_back) state_d = ST_MOVE_BACK;
          else              state_d = ST_IDLE;
        end
      endcase
    end

    // kb also marks a BLOCKSTUN restart, which must reload the counter.
    if (state_d != state_q || kb || !timed) cnt_d = '0;
    else                                    cnt_d = cnt_q + 8'd1;

    // Movement follows the pre-tick state; knockback joins the same sum.
    step = '0;
    if (state_q == ST_MOVE_FWD)  step = FWD_STEP;
    if (state_q == ST_MOVE_BACK) step = -FWD_STEP;
    if (kb)                      step = step - FWD_KB;
    nx = sx_t'({2'b00, posx_q}) + step;
    if (nx < XLO)      posx_d = W'(X_MIN);
    else if (nx > XHI) posx_d = W'(X_MAX);
    else               posx_d = nx[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      posx_q   <= X_INIT;
      health_q <= 8'(HEALTH_MAX);
      atk_q    <= 1'b0;
    end else if (frame_tick) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      posx_q   <= posx_d;
      health_q <= health_d;
      atk_q    <= attack;
    end
  end

  assign posx          = posx_q;
  assign posy          = W'(POS_Y);
  assign state         = state_q;
  assign hitbox_active = (state_q == ST_ATK_ACTIVE);
  assign health        = health_q;
  assign ko            = (state_q == ST_KO);

  player_box_mirror #(.W(W), .SIDE(SIDE), .X_LO(HB_X_LO), .X_HI(HB_X_HI),
                      .Y_LO(HB_Y_LO), .Y_HI(HB_Y_HI)) u_hitbox (
    .posx_i(posx_q), .posy_i(posy),
    .x1_o(hitbox_x1), .x2_o(hitbox_x2), .y1_o(hitbox_y1), .y2_o(hitbox_y2)
  );

  player_box_mirror #(.W(W), .SIDE(SIDE), .X_LO(HU_X_LO), .X_HI(HU_X_HI),
                      .Y_LO(HU_Y_LO), .Y_HI(HU_Y_HI)) u_hurtbox (
    .posx_i(posx_q), .posy_i(posy),
    .x1_o(hurtbox_x1), .x2_o(hurtbox_x2), .y1_o(hurtbox_y1), .y2_o(hurtbox_y2)
  );

endmodule

// File: tb/tb_player_fsm_v2.sv
// Bench for player_fsm_v2: one left (SIDE 0) and one right (SIDE 1) player.
// A frame-level model (countdown timers, plain integer positions) runs beside
// the DUTs and is compared on every falling clock edge after reset.
module tb_player_fsm_v2;

  logic       clk, rst_n, frame_tick;
  logic       lft [2], rgt [2], atk [2], hit [2];
  logic [9:0] posx_o [2], posy_o [2];
  logic [3:0] state_o [2];
  logic       hba_o [2], ko_o [2];
  logic [9:0] hbx1 [2], hbx2 [2], hby1 [2], hby2 [2];
  logic [9:0] hux1 [2], hux2 [2], huy1 [2], huy2 [2];
  logic [7:0] health_o [2];

  int checks = 0, failures = 0;
  bit go = 0;

  player_fsm_v2 #(.SIDE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .left(lft[0]), .right(rgt[0]), .attack(atk[0]), .hit_in(hit[0]),
    .posx(posx_o[0]), .posy(posy_o[0]), .state(state_o[0]), .hitbox_active(hba_o[0]),
    .hitbox_x1(hbx1[0]), .hitbox_x2(hbx2[0]), .hitbox_y1(hby1[0]), .hitbox_y2(hby2[0]),
    .hurtbox_x1(hux1[0]), .hurtbox_x2(hux2[0]), .hurtbox_y1(huy1[0]), .hurtbox_y2(huy2[0]),
    .health(health_o[0]), .ko(ko_o[0]));

  player_fsm_v2 #(.SIDE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .left(lft[1]), .right(rgt[1]), .attack(atk[1]), .hit_in(hit[1]),
    .posx(posx_o[1]), .posy(posy_o[1]), .state(state_o[1]), .hitbox_active(hba_o[1]),
    .hitbox_x1(hbx1[1]), .hitbox_x2(hbx2[1]), .hitbox_y1(hby1[1]), .hitbox_y2(hby2[1]),
    .hurtbox_x1(hux1[1]), .hurtbox_x2(hux2[1]), .hurtbox_y1(huy1[1]), .hurtbox_y2(huy2[1]),
    .health(health_o[1]), .ko(ko_o[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- frame-level model ----------------
  typedef struct packed { int st; int px; int hp; int left; bit atk_prev; } pm_t;
  pm_t m [2];

  function automatic pm_t mstep(pm_t s, int side, bit l, bit r, bit a, bit h);
    pm_t n = s;
    int toward = (side == 0) ? 1 : -1;   // +x direction that faces the opponent
    int dx = 0;
    n.atk_prev = a;
    if (s.st == 1) dx = toward * 5;
    if (s.st == 2) dx = -toward * 5;
    if (s.st == 8) begin
      n.left = 0;
    end else if (h && s.st != 6) begin
      if (s.st == 2 || s.st == 7) begin
        n.st = 7; n.left = 6; dx -= toward * 8;
      end else begin
        n.hp = (s.hp > 10) ? s.hp - 10 : 0;
        if (n.hp == 0) begin n.st = 8; n.left = 0; end
        else begin n.st = 6; n.left = 12; dx -= toward * 8; end
      end
    end else if (s.left > 0) begin
      n.left = s.left - 1;
      if (n.left == 0) begin
        if (s.st == 3)      begin n.st = 4; n.left = 2;  end
        else if (s.st == 4) begin n.st = 5; n.left = 16; end
        else                n.st = 0;
      end
    end else begin
      if (a && !s.atk_prev) begin n.st = 3; n.left = 5; end
      else if (l && r) n.st = 2;
      else if (r)      n.st = (side == 0) ? 1 : 2;
      else if (l)      n.st = (side == 0) ? 2 : 1;
      else             n.st = 0;
    end
    n.px = s.px + dx;
    if (n.px < 50)  n.px = 50;
    if (n.px > 490) n.px = 490;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '{st: 0, px: 210, hp: 100, left: 0, atk_prev: 1'b0};
      m[1] <= '{st: 0, px: 420, hp: 100, left: 0, atk_prev: 1'b0};
    end else if (frame_tick) begin
      m[0] <= mstep(m[0], 0, lft[0], rgt[0], atk[0], hit[0]);
      m[1] <= mstep(m[1], 1, lft[1], rgt[1], atk[1], hit[1]);
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (go) begin
      for (int p = 0; p < 2; p++) begin
        int hl, hh;
        hl = (p == 0) ? 37 : 64;
        hh = (p == 0) ? 86 : 113;
        cmp($sformatf("p%0d posx", p),   int'(posx_o[p]),   m[p].px);
        cmp($sformatf("p%0d posy", p),   int'(posy_o[p]),   170);
        cmp($sformatf("p%0d state", p),  int'(state_o[p]),  m[p].st);
        cmp($sformatf("p%0d health", p), int'(health_o[p]), m[p].hp);
        cmp($sformatf("p%0d ko", p),     int'(ko_o[p]),     int'(m[p].st == 8));
        cmp($sformatf("p%0d hb_act", p), int'(hba_o[p]),    int'(m[p].st == 4));
        cmp($sformatf("p%0d hb_x1", p),  int'(hbx1[p]),     m[p].px + 37);
        cmp($sformatf("p%0d hb_x2", p),  int'(hbx2[p]),     m[p].px + 113);
        cmp($sformatf("p%0d hb_y1", p),  int'(hby1[p]),     170 + 24);
        cmp($sformatf("p%0d hb_y2", p),  int'(hby2[p]),     170 + 57);
        cmp($sformatf("p%0d hu_x1", p),  int'(hux1[p]),     m[p].px + hl);
        cmp($sformatf("p%0d hu_x2", p),  int'(hux2[p]),     m[p].px + hh);
        cmp($sformatf("p%0d hu_y1", p),  int'(huy1[p]),     170);
        cmp($sformatf("p%0d hu_y2", p),  int'(huy2[p]),     320);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk); frame_tick = 1;
      @(negedge clk); frame_tick = 0;
    end
  endtask

  task automatic clr_in();
    for (int p = 0; p < 2; p++) begin
      lft[p] = 0; rgt[p] = 0; atk[p] = 0; hit[p] = 0;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    clr_in();
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    int n3, n4, nha, n5;
    rst_n = 0; frame_tick = 0; clr_in();
    repeat (2) @(negedge clk);
    rst_n = 1; go = 1;

    // reset values
    cmp("rst posx0", posx_o[0], 210);
    cmp("rst posy0", posy_o[0], 170);
    cmp("rst state0", state_o[0], 0);
    cmp("rst health0", health_o[0], 100);
    cmp("rst posx1", posx_o[1], 420);

    // walk forward, one-frame position lag
    rgt[0] = 1;
    tick(1); cmp("fwd t1 state", state_o[0], 1); cmp("fwd t1 posx", posx_o[0], 210);
    tick(1); cmp("fwd t2 posx", posx_o[0], 215);
    tick(1); cmp("fwd t3 posx", posx_o[0], 220);
    rgt[0] = 0;
    tick(1); cmp("stop state", state_o[0], 0); cmp("stop posx", posx_o[0], 225);
    // inputs without frame_tick must change nothing
    atk[0] = 1; hit[0] = 1; repeat (4) @(negedge clk); atk[0] = 0; hit[0] = 0;
    cmp("no tick state", state_o[0], 0);
    cmp("no tick health", health_o[0], 100);

    // clamps: knock both back, then walk away into the walls
    do_reset();
    hit[0] = 1; hit[1] = 1;
    tick(1); cmp("kb0 posx", posx_o[0], 202); cmp("kb1 posx", posx_o[1], 428);
    hit[0] = 0; hit[1] = 0;
    tick(12);
    rgt[1] = 1;
    tick(13); cmp("p1 at 488", posx_o[1], 488);
    tick(1);  cmp("p1 clamp", posx_o[1], 490);
    tick(1);  cmp("p1 hold clamp", posx_o[1], 490);
    rgt[1] = 0; tick(1);
    lft[0] = 1;
    tick(31); cmp("p0 at 52", posx_o[0], 52);
    tick(1);  cmp("p0 clamp", posx_o[0], 50);
    tick(1);  cmp("p0 hold clamp", posx_o[0], 50);
    lft[0] = 0; tick(1);

    // attack phase lengths, held button
    do_reset();
    atk[0] = 1;
    n3 = 0; n4 = 0; nha = 0; n5 = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (state_o[0] == 3) n3++;
      if (state_o[0] == 4) n4++;
      if (hba_o[0]) nha++;
      if (state_o[0] == 5) n5++;
    end
    cmp("startup ticks", n3, 5);
    cmp("active ticks", n4, 2);
    cmp("hitbox ticks", nha, 2);
    cmp("recovery ticks", n5, 16);
    cmp("atk end state", state_o[0], 0);
    tick(3); cmp("held no retrigger", state_o[0], 0);
    atk[0] = 0; tick(1);
    atk[0] = 1; tick(1); cmp("retrigger", state_o[0], 3);
    atk[0] = 0; tick(23); cmp("retrigger done", state_o[0], 0);

    // hit during startup, then hit ignored during hitstun
    do_reset();
    atk[0] = 1; tick(1);
    hit[0] = 1; tick(1);
    cmp("hit state", state_o[0], 6);
    cmp("hit health", health_o[0], 90);
    cmp("hit posx", posx_o[0], 202);
    cmp("hit hb_act", hba_o[0], 0);
    hit[0] = 0;
    tick(11); cmp("hitstun len", state_o[0], 6);
    tick(1);  cmp("hitstun end", state_o[0], 0);
    hit[0] = 1; tick(1); cmp("hit2 health", health_o[0], 80); cmp("hit2 posx", posx_o[0], 194);
    tick(1);
    cmp("hit in stun state", state_o[0], 6);
    cmp("hit in stun health", health_o[0], 80);
    cmp("hit in stun posx", posx_o[0], 194);
    hit[0] = 0; atk[0] = 0;
    tick(11); cmp("hitstun2 end", state_o[0], 0);

    // block while retreating
    lft[0] = 1; tick(1); cmp("back state", state_o[0], 2);
    hit[0] = 1; tick(1);
    cmp("block state", state_o[0], 7);
    cmp("block health", health_o[0], 80);
    cmp("block posx", posx_o[0], 181);
    hit[0] = 0;
    tick(5); cmp("blockstun len", state_o[0], 7);
    tick(1); cmp("blockstun end", state_o[0], 0);
    lft[0] = 0; tick(1);

    // ten unblocked hits to KO
    do_reset();
    for (int i = 0; i < 10; i++) begin
      hit[0] = 1; tick(1);
      cmp($sformatf("ko run health %0d", i), health_o[0], 90 - 10 * i);
      hit[0] = 0; tick(12);
    end
    cmp("ko state", state_o[0], 8);
    cmp("ko flag", ko_o[0], 1);
    cmp("ko posx", posx_o[0], 138);
    rgt[0] = 1; atk[0] = 1; hit[0] = 1;
    tick(5);
    cmp("ko sticky state", state_o[0], 8);
    cmp("ko sticky posx", posx_o[0], 138);
    cmp("ko sticky health", health_o[0], 0);
    clr_in();

    // asynchronous reset in the middle of an attack
    do_reset();
    rgt[0] = 1; tick(2);
    atk[0] = 1; tick(1);
    rgt[0] = 0; tick(1);
    cmp("pre-rst state", state_o[0], 3);
    cmp("pre-rst posx", posx_o[0], 220);
    #2 rst_n = 0;
    #1;
    cmp("async rst state", state_o[0], 0);
    cmp("async rst posx", posx_o[0], 210);
    clr_in();
    @(negedge clk); rst_n = 1;
    tick(2);

    go = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
